// File: rtl/sprite_fetch_scheduler_pkg.sv
// Shared display/sprite constants and types for the sprite fetch scheduler.
// These sit alongside the existing game constants.
package sprite_fetch_scheduler_pkg;

  // Visible raster
  localparam int H_DISPLAY = 640;
  localparam int V_DISPLAY = 480;

  // Sprite geometry
  localparam int FROG_W   = 32;
  localparam int CAR_W    = 36;
  localparam int CAR_H    = 32;
  localparam int NUM_CARS = 6;

  // Foreground ROM layout: player image at 0, car image above it
  localparam int FG_PLAYER_BASE = 0;
  localparam int FG_CAR_BASE    = 1024;

  // Background ROM layout: one 1024-word page per background type
  localparam int BG_PAGE   = 1024;
  localparam int TILE      = 32;
  localparam int TILE_BITS = $clog2(TILE);

  // Colour 0 is see-through in every sprite image
  localparam logic [8:0] TRANSPARENT = 9'h000;

  typedef enum logic [1:0] {
    BG_NONE   = 2'd0,
    BG_ROAD   = 2'd1,
    BG_GRASS  = 2'd2,
    BG_GROUND = 2'd3
  } bg_type_e;

  typedef enum logic {
    ST_BLANK  = 1'b0,
    ST_ACTIVE = 1'b1
  } frame_state_e;

  // Per-pixel bookkeeping carried alongside the ROM fetch
  typedef struct packed {
    logic       visible;     // pixel lies inside the displayed raster
    logic       in_frame;    // frame state machine is ACTIVE for this pixel
    logic       has_owner;   // some sprite owns the foreground port
    logic       player_own;  // the player owns it (player hit)
    logic       car_any;     // at least one car covers the pixel
    logic [2:0] car_idx;     // lowest covering car
    logic       bg_none;     // no background image for this pixel
  } pix_tag_t;

  // Column inside the car image, mirrored when the car faces the other way
  function automatic logic [5:0] car_col(input logic [5:0] dx, input logic flip);
    return flip ? (6'(CAR_W - 1) - dx) : dx;
  endfunction

endpackage

// File: rtl/sprite_fetch_scheduler_hit.sv
// Rectangle hit test for one sprite plus the pixel offset inside it.
// Sums are formed at 11 bits so sprites near the right/bottom edge never wrap.
module sprite_hit_decode
  import sprite_fetch_scheduler_pkg::*;
#(
  parameter int W = FROG_W,
  parameter int H = FROG_W
) (
  input  logic [9:0] i_h,
  input  logic [9:0] i_v,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  output logic       o_hit,
  output logic [5:0] o_dx,
  output logic [5:0] o_dy
);

  logic [10:0] w_x_end;
  logic [10:0] w_y_end;

  assign w_x_end = {1'b0, i_x} + 11'(W);
  assign w_y_end = {1'b0, i_y} + 11'(H);

  assign o_hit = (i_h >= i_x) && ({1'b0, i_h} < w_x_end) &&
                 (i_v >= i_y) && ({1'b0, i_v} < w_y_end);

  // Offsets are only meaningful when o_hit is set, so 6 bits suffice
  assign o_dx = 6'(i_h - i_x);
  assign o_dy = 6'(i_v - i_y);

endmodule

// File: rtl/sprite_fetch_scheduler.sv
// Pixel-rate sprite fetch scheduler: owner arbitration, ROM addressing,
// transparency compositing, collision latch and frame-start detection.
// Pixel (h,v) presented in a cycle yields rgb three clock edges later.
module sprite_fetch_scheduler
  import sprite_fetch_scheduler_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  input  logic [9:0]  player_x,
  input  logic [9:0]  player_y,
  input  logic [59:0] car_x,
  input  logic [59:0] car_y,
  input  logic [5:0]  car_flip,
  input  logic [1:0]  bg_type,
  output logic [11:0] fg_addr,
  input  logic [8:0]  fg_data,
  output logic [11:0] bg_addr,
  input  logic [8:0]  bg_data,
  output logic [8:0]  rgb,
  output logic        collision_valid,
  output logic [2:0]  collision_car,
  input  logic        collision_ack,
  output logic        frame_start
);

  // ---------------------------------------------------------------- S0 decode
  logic                w_pl_hit;
  logic [5:0]          w_pl_dx;
  logic [5:0]          w_pl_dy;
  logic [NUM_CARS-1:0] w_car_hit;
  logic [5:0]          w_car_dx [NUM_CARS];
  logic [5:0]          w_car_dy [NUM_CARS];

  sprite_hit_decode #(.W(FROG_W), .H(FROG_W)) u_player_hit (
    .i_h   (h_count),
    .i_v   (v_count),
    .i_x   (player_x),
    .i_y   (player_y),
    .o_hit (w_pl_hit),
    .o_dx  (w_pl_dx),
    .o_dy  (w_pl_dy)
  );

  for (genvar gi = 0; gi < NUM_CARS; gi++) begin : g_car
    sprite_hit_decode #(.W(CAR_W), .H(CAR_H)) u_car_hit (
      .i_h   (h_count),
      .i_v   (v_count),
      .i_x   (car_x[10*gi +: 10]),
      .i_y   (car_y[10*gi +: 10]),
      .o_hit (w_car_hit[gi]),
      .o_dx  (w_car_dx[gi]),
      .o_dy  (w_car_dy[gi])
    );
  end

  // Fixed-priority owner select (player first, then lowest car) and its address
  logic        w_car_any;
  logic [2:0]  w_car_idx;
  logic [5:0]  w_car_row;
  logic [5:0]  w_car_col;
  logic [11:0] w_fg_addr_next;

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    w_car_idx      = '0;
    w_car_row      = '0;
    w_car_col      = '0;
    w_fg_addr_next = '0;
    // Scan downwards so the lowest-numbered hit is the one left standing
    for (int i = NUM_CARS - 1; i >= 0; i--) begin
      if (w_car_hit[i]) begin
        w_car_idx = 3'(i);
        w_car_row = w_car_dy[i];
        w_car_col = car_col(w_car_dx[i], car_flip[i]);
      end
    end
    w_car_any = |w_car_hit;
    if (w_pl_hit) begin
      w_fg_addr_next = 12'(FG_PLAYER_BASE) + 12'(w_pl_dy) * 12'(FROG_W) + 12'(w_pl_dx);
    end else if (w_car_any) begin
      w_fg_addr_next = 12'(FG_CAR_BASE) + 12'(w_car_row) * 12'(CAR_W) + 12'(w_car_col);
    end
  end

  // Background tile address: one page per background type, tiles repeat every TILE
  logic [1:0]  w_bg_page;
  logic [11:0] w_bg_addr_next;

  always_comb begin
    w_bg_page      = bg_type - 2'd1;
    w_bg_addr_next = '0;
    if (bg_type != BG_NONE) begin
      w_bg_addr_next = 12'(w_bg_page) * 12'(BG_PAGE)
                     + 12'(v_count[TILE_BITS-1:0]) * 12'(TILE)
                     + 12'(h_count[TILE_BITS-1:0]);
    end
  end

  // ------------------------------------------------------------- frame FSM
  frame_state_e r_state;
  frame_state_e w_state_next;
  logic         w_frame_pulse;

  // Next state: enter ACTIVE at the top-left pixel, leave at the first line below the raster
  always_comb begin
    w_state_next  = r_state;
    w_frame_pulse = 1'b0;
    case (r_state)
      ST_BLANK: begin
        if (h_count == 10'd0 && v_count == 10'd0) begin
          w_state_next  = ST_ACTIVE;
          w_frame_pulse = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (h_count == 10'd0 && v_count == 10'(V_DISPLAY)) begin
          w_state_next = ST_BLANK;
        end
      end
      default: w_state_next = ST_BLANK;
    endcase
  end

  // Frame state register
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (!RST_N) begin
      r_state <= ST_BLANK;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Pulse lines up with the pixel being presented; held low while in reset
  assign frame_start = w_frame_pulse & RST_N;

  // Tag describing the presented pixel
  pix_tag_t w_s0_tag;

  always_comb begin
    w_s0_tag            = '0;
    w_s0_tag.visible    = (h_count < 10'(H_DISPLAY)) && (v_count < 10'(V_DISPLAY));
    w_s0_tag.in_frame   = (w_state_next == ST_ACTIVE);
    w_s0_tag.has_owner  = w_pl_hit | w_car_any;
    w_s0_tag.player_own = w_pl_hit;
    w_s0_tag.car_any    = w_car_any;
    w_s0_tag.car_idx    = w_car_idx;
    w_s0_tag.bg_none    = (bg_type == BG_NONE);
  end

  // ------------------------------------------------------- S1 / S2 pipeline
  pix_tag_t r_s1_tag;
  pix_tag_t r_s2_tag;

  // S1 registers the addresses that go to the ROMs; S2 waits out the ROM latency
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_s1_tag <= '0;
      r_s2_tag <= '0;
      fg_addr  <= '0;
      bg_addr  <= '0;
    end else begin
      r_s1_tag <= w_s0_tag;
      r_s2_tag <= r_s1_tag;
      fg_addr  <= w_fg_addr_next;
      bg_addr  <= w_bg_addr_next;
    end
  end

  // ---------------------------------------------------------- S3 composite
  logic [8:0] w_bg_colour;
  logic       w_fg_opaque;
  logic [8:0] w_pixel;
  logic       w_event;

  // Foreground wins only where an owner exists and its colour is not see-through
  always_comb begin
    w_bg_colour = r_s2_tag.bg_none ? TRANSPARENT : bg_data;
    w_fg_opaque = r_s2_tag.has_owner && (fg_data != TRANSPARENT);
    w_pixel     = '0;
    if (r_s2_tag.visible) begin
      w_pixel = w_fg_opaque ? fg_data : w_bg_colour;
    end
    // With the player owning the port, fg_data is the player's own pixel
    w_event = r_s2_tag.visible && r_s2_tag.in_frame && r_s2_tag.player_own &&
              r_s2_tag.car_any && (fg_data != TRANSPARENT);
  end

  // Output colour register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rgb <= '0;
    end else begin
      rgb <= w_pixel;
    end
  end

  // Collision latch: acknowledge beats a simultaneous event; held while valid
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      collision_valid <= 1'b0;
      collision_car   <= '0;
    end else if (collision_valid && collision_ack) begin
      collision_valid <= 1'b0;
    end else if (!collision_valid && w_event) begin
      collision_valid <= 1'b1;
      collision_car   <= r_s2_tag.car_idx;
    end
  end

endmodule

// File: tb/tb_sprite_fetch_scheduler.sv
// Self-checking bench: randomized and directed pixels are run through a
// behavioural reference model; expectations are queued with the cycle they
// are due and a monitor compares them against the DUT outputs.
module tb_sprite_fetch_scheduler;

  localparam int H_DISPLAY   = 640;
  localparam int V_DISPLAY   = 480;
  localparam int FROG_W      = 32;
  localparam int CAR_W       = 36;
  localparam int CAR_H       = 32;
  localparam int FG_CAR_BASE = 1024;
  localparam int TILE        = 32;
  localparam int FAR         = 900;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [9:0]  h_count = '0, v_count = '0, player_x = '0, player_y = '0;
  logic [59:0] car_x = '0, car_y = '0;
  logic [5:0]  car_flip = '0;
  logic [1:0]  bg_type = '0;
  logic [11:0] fg_addr, bg_addr;
  logic [8:0]  fg_data = '0, bg_data = '0;
  logic [8:0]  rgb;
  logic        collision_valid;
  logic [2:0]  collision_car;
  logic        collision_ack = 1'b0;
  logic        frame_start;

  sprite_fetch_scheduler dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .h_count         (h_count),
    .v_count         (v_count),
    .player_x        (player_x),
    .player_y        (player_y),
    .car_x           (car_x),
    .car_y           (car_y),
    .car_flip        (car_flip),
    .bg_type         (bg_type),
    .fg_addr         (fg_addr),
    .fg_data         (fg_data),
    .bg_addr         (bg_addr),
    .bg_data         (bg_data),
    .rgb             (rgb),
    .collision_valid (collision_valid),
    .collision_car   (collision_car),
    .collision_ack   (collision_ack),
    .frame_start     (frame_start)
  );

  always #5 CLK = ~CLK;

  // Sprite ROMs with one cycle of registered read latency
  logic [8:0] fg_rom [4096];
  logic [8:0] bg_rom [4096];
  always @(posedge CLK) begin
    fg_data <= fg_rom[fg_addr];
    bg_data <= bg_rom[bg_addr];
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expectation queues, one per output latency
  typedef struct { int due; bit fs; } exp0_t;
  typedef struct { int due; bit chk_fg; int fg; bit chk_bg; int bg; bit cv; int cc; } exp1_t;
  typedef struct { int due; int rgb; } exp3_t;
  typedef struct { bit ev; int idx; } ev_t;

  exp0_t q0[$];
  exp1_t q1[$];
  exp3_t q3[$];
  ev_t   hist[$];

  // Reference model state
  int px, py;
  int cx[6], cy[6];
  bit cflip[6];
  bit m_active = 0;
  bit m_cv = 0;
  int m_cc = 0;

  function automatic bit in_rect(int h, int v, int x, int y, int w, int hh);
    return (h >= x) && (h < x + w) && (v >= y) && (v < y + hh);
  endfunction

  function automatic int clamp10(int x);
    return (x < 0) ? 0 : ((x > 1023) ? 1023 : x);
  endfunction

  // Present one pixel for one cycle and queue everything the model predicts for it
  task automatic present(input int h, input int v, input int bt, input bit ack);
    bit    p_hit, owner, vis, fs, ev, cv_ev;
    int    first_car, fa, ba, col, fgd, bgc, exp_rgb, cv_idx;
    exp0_t e0;
    exp1_t e1;
    exp3_t e3;
    ev_t   he;

    h_count = 10'(h);  v_count = 10'(v);
    player_x = 10'(px); player_y = 10'(py);
    for (int i = 0; i < 6; i++) begin
      car_x[10*i +: 10] = 10'(cx[i]);
      car_y[10*i +: 10] = 10'(cy[i]);
      car_flip[i]       = cflip[i];
    end
    bg_type = 2'(bt);
    collision_ack = ack;

    p_hit = in_rect(h, v, px, py, FROG_W, FROG_W);
    first_car = -1;
    for (int i = 0; i < 6; i++)
      if (first_car < 0 && in_rect(h, v, cx[i], cy[i], CAR_W, CAR_H)) first_car = i;
    owner = p_hit || (first_car >= 0);
    fa = 0;
    if (p_hit) fa = (v - py) * FROG_W + (h - px);
    else if (first_car >= 0) begin
      col = h - cx[first_car];
      if (cflip[first_car]) col = CAR_W - 1 - col;
      fa = FG_CAR_BASE + (v - cy[first_car]) * CAR_W + col;
    end
    ba = (bt == 0) ? 0 : (bt - 1) * 1024 + (v % TILE) * TILE + (h % TILE);
    vis = (h < H_DISPLAY) && (v < V_DISPLAY);

    fs = !m_active && h == 0 && v == 0;
    if (!m_active && h == 0 && v == 0) m_active = 1;
    else if (m_active && h == 0 && v == V_DISPLAY) m_active = 0;

    fgd = owner ? int'(fg_rom[fa]) : 0;
    bgc = (bt == 0) ? 0 : int'(bg_rom[ba]);
    exp_rgb = !vis ? 0 : ((owner && fgd != 0) ? fgd : bgc);
    ev = vis && m_active && p_hit && (first_car >= 0) && (fgd != 0);

    // The event of the pixel two cycles back meets this cycle's ack at the same edge
    he.ev = ev; he.idx = first_car;
    hist.push_back(he);
    if (hist.size() > 3) void'(hist.pop_front());
    cv_ev = 0; cv_idx = 0;
    if (hist.size() == 3) begin cv_ev = hist[0].ev; cv_idx = hist[0].idx; end
    if (m_cv && ack) m_cv = 0;
    else if (!m_cv && cv_ev) begin m_cv = 1; m_cc = cv_idx; end

    e0.due = cyc; e0.fs = fs;
    q0.push_back(e0);
    e1.due = cyc + 1; e1.chk_fg = owner; e1.fg = fa; e1.chk_bg = (bt != 0); e1.bg = ba;
    e1.cv = m_cv; e1.cc = m_cc;
    q1.push_back(e1);
    e3.due = cyc + 3; e3.rgb = exp_rgb;
    q3.push_back(e3);

    @(posedge CLK);
    #1;
  endtask

  // Monitor: compare whatever is due this cycle, away from the active edge
  exp0_t m0;
  exp1_t m1;
  exp3_t m3;
  always @(negedge CLK) begin
    while (q0.size() > 0 && q0[0].due <= cyc) begin
      m0 = q0.pop_front();
      if (m0.due < cyc) check("frame_start late", 32'(cyc), 32'(m0.due));
      else check("frame_start", 32'(frame_start), 32'(m0.fs));
    end
    while (q1.size() > 0 && q1[0].due <= cyc) begin
      m1 = q1.pop_front();
      if (m1.due < cyc) check("s1 late", 32'(cyc), 32'(m1.due));
      else begin
        if (m1.chk_fg) check("fg_addr", 32'(fg_addr), 32'(m1.fg));
        if (m1.chk_bg) check("bg_addr", 32'(bg_addr), 32'(m1.bg));
        check("collision_valid", 32'(collision_valid), 32'(m1.cv));
        if (m1.cv) check("collision_car", 32'(collision_car), 32'(m1.cc));
      end
    end
    while (q3.size() > 0 && q3[0].due <= cyc) begin
      m3 = q3.pop_front();
      if (m3.due < cyc) check("rgb late", 32'(cyc), 32'(m3.due));
      else check("rgb", 32'(rgb), 32'(m3.rgb));
    end
  end

  task automatic cars_far();
    for (int i = 0; i < 6; i++) begin cx[i] = FAR; cy[i] = FAR; cflip[i] = 0; end
  endtask

  task automatic randomize_scene();
    px = int'($urandom_range(0, 650));
    py = int'($urandom_range(0, 500));
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        cx[i] = clamp10(px + int'($urandom_range(0, 60)) - 30);
        cy[i] = clamp10(py + int'($urandom_range(0, 60)) - 30);
      end else begin
        cx[i] = int'($urandom_range(0, 700));
        cy[i] = int'($urandom_range(0, 520));
      end
      cflip[i] = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    int h, v, sel, k;
    for (int i = 0; i < 4096; i++) begin
      fg_rom[i] = ($urandom_range(0, 3) == 0) ? 9'h000 : 9'($urandom_range(1, 511));
      bg_rom[i] = 9'($urandom_range(0, 511));
    end
    px = 100; py = 100;
    cars_far();

    // Reset held with (0,0) on the counters: everything quiet
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset rgb", 32'(rgb), 32'h0);
    check("reset collision_valid", 32'(collision_valid), 32'h0);
    check("reset collision_car", 32'(collision_car), 32'h0);
    check("reset fg_addr", 32'(fg_addr), 32'h0);
    check("reset bg_addr", 32'(bg_addr), 32'h0);
    check("reset frame_start", 32'(frame_start), 32'h0);

    // Release at pixel (0,0) with the player at (100,100)
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    present(0, 0, 1, 0);

    // Player pixel with a known colour
    fg_rom[(103 - 100) * FROG_W + (105 - 100)] = 9'h1C7;
    present(105, 103, 1, 0);

    // Car 2 mirrored, then not mirrored
    cx[2] = 200; cy[2] = 64; cflip[2] = 1;
    present(200, 64, 2, 0);
    cflip[2] = 0;
    present(200, 64, 2, 0);

    // Player over car 0 but transparent there: background shows, no collision
    px = 0; py = 64; cx[0] = 0; cy[0] = 64;
    fg_rom[202] = 9'h000;
    bg_rom[202] = 9'h0AB;
    present(10, 70, 1, 0);

    // Collision with cars 3 and 5; car 3 leaves, ack collides with a new event
    cars_far();
    px = 300; py = 200; cx[3] = 290; cy[3] = 190; cx[5] = 295; cy[5] = 195;
    for (int i = 0; i < 12; i++) fg_rom[5 * FROG_W + i] = 9'h155;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) cx[3] = FAR;
      present(300 + i, 205, 1, (i == 5) || (i == 10));
    end
    present(50, 50, 0, 1);
    present(50, 50, 0, 0);
    present(50, 50, 0, 0);

    // Player covering pixels just outside the raster
    px = 620; py = 0; cx[0] = 620; cy[0] = 0;
    fg_rom[10 * FROG_W + 20] = 9'h0F0;
    present(640, 10, 1, 0);
    px = 0; py = 470; cx[0] = 0; cy[0] = 470;
    fg_rom[10 * FROG_W + 10] = 9'h0F0;
    present(10, 480, 1, 0);
    present(50, 50, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 40 == 0) randomize_scene();
      sel = int'($urandom_range(0, 9));
      if (sel < 4) begin
        h = px + int'($urandom_range(0, 40)) - 4;
        v = py + int'($urandom_range(0, 40)) - 4;
      end else if (sel < 8) begin
        k = int'($urandom_range(0, 5));
        h = cx[k] + int'($urandom_range(0, 44)) - 4;
        v = cy[k] + int'($urandom_range(0, 40)) - 4;
      end else if (sel == 8) begin
        h = int'($urandom_range(0, 700));
        v = int'($urandom_range(0, 520));
      end else begin
        h = 0;
        v = ($urandom_range(0, 1) == 1) ? 0 : V_DISPLAY;
      end
      present(clamp10(h), clamp10(v), int'($urandom_range(0, 3)), $urandom_range(0, 5) == 0);
    end

    repeat (6) @(negedge CLK);
    check("queues drained", 32'(q0.size() + q1.size() + q3.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
